spi_req_arbiter: RTL

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

---
 rtl/spi_arb_pkg.sv | 15 +
 rtl/spi_rr_picker.sv | 33 +++
 rtl/spi_req_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and default sizing for the SPI request arbiter.
package spi_arb_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefDw   = 8;
  localparam int unsigned DefTmo  = 255;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module spi_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_win_oh,
  output logic [IW-1:0]   o_win_idx,
  output logic            o_win_vld
);

  logic [IW-1:0] w_j;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    o_win_vld = 1'b0;
    w_j       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IW'((32'(i_ptr) + 32'(k)) % NREQ);
      if (!o_win_vld && i_req[w_j]) begin
        o_win_vld     = 1'b1;
        o_win_oh[w_j] = 1'b1;
        o_win_idx     = w_j;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master between NREQ requesters,
// with a per-transfer done timeout.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned DW   = DefDw,
  parameter int unsigned TMO  = DefTmo
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]  o_gnt,
  output logic [NREQ-1:0]  o_rsp_valid,
  output logic [DW-1:0]    o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_m_start,
  output logic [DW-1:0]    o_m_tx,
  input  logic [DW-1:0]    i_m_rx,
  input  logic             i_m_done,
  output logic [NREQ-1:0]  o_m_cs_sel,
  output logic             o_busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TmoVal  = CW'(TMO);
  localparam logic [IW-1:0] LastIdx = IW'(NREQ - 1);

  arb_state_e      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_win_idx;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rsp_err;
  logic            r_m_start;
  logic [DW-1:0]   r_m_tx;

  logic [NREQ-1:0] w_win_oh;
  logic [IW-1:0]   w_win_idx;
  logic            w_win_vld;

  spi_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_win_vld (w_win_vld)
  );

  // Transaction FSM with all outputs registered. r_cnt counts cycles since
  // the m_start cycle, so the timeout fires TMO cycles after m_start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_win_idx   <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_m_start   <= 1'b0;
      r_m_tx      <= '0;
    end else begin
      r_m_start   <= 1'b0;
      r_rsp_valid <= '0;
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_win_vld) begin
            r_gnt     <= w_win_oh;
            r_win_idx <= w_win_idx;
            r_m_tx    <= i_req_data[w_win_idx*DW +: DW];
            r_m_start <= 1'b1;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= r_cnt + CW'(1);
          r_state <= StWait;
        end
        StWait: begin
          // Done takes priority over a coincident timeout.
          if (i_m_done) begin
            r_rsp_valid <= r_gnt;
            r_rsp_data  <= i_m_rx;
            r_rsp_err   <= 1'b0;
            r_state     <= StResp;
          end else if (r_cnt >= TmoVal) begin
            r_rsp_valid <= r_gnt;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StResp: begin
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_ptr   <= (r_win_idx == LastIdx) ? '0 : r_win_idx + IW'(1);
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_m_cs_sel  = r_gnt;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_m_start   = r_m_start;
  assign o_m_tx      = r_m_tx;
  assign o_busy      = (r_state != StIdle);

endmodule
